irb_capture: RTL and testbench
==============================

# irb_capture

Downstream image-result buffer for the LCD controller. It captures the 64-pixel write-back stream (IRB_RW/IRB_A/IRB_D) into an 8×8 local array, seals the image when the controller raises `done`, and optionally runs a checksum scan. It then serves the stored image to the test/host side through a one-cycle-latency read port.

## Interface
- `DEPTH`, 64: number of pixels (8×8 image).
- `ADDR_W`, 6: pixel address width, equal to log2(`DEPTH`).
- `DATA_W`, 8: pixel width.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `IRB_RW` input 1: write strobe from the controller; 0 = write this cycle, 1 = idle.
- `IRB_A` input `ADDR_W`: write address.
- `IRB_D` input `DATA_W`: write data.
- `done` input 1: controller finished its write-back; level signal.
- `rd_en` input 1: read request, honoured only while `ready`=1.
- `rd_addr` input `ADDR_W`: read address.
- `rd_data` output `DATA_W`: read data, registered.
- `rd_valid` output 1: one-cycle pulse qualifying `rd_data`.
- `ready` output 1: image sealed (and, if enabled, checksum valid).
- `wr_count` output `ADDR_W+1`: number of write strobes accepted since the last capture start, saturating at `DEPTH`.
- `checksum` output 16: mod-2^16 sum of all stored pixels.

## Operation
- The block has three states: CAPTURE, SCAN and READY. Reset enters CAPTURE.
- **CAPTURE**
  - Every edge with `IRB_RW`=0 writes `mem[IRB_A]`←`IRB_D` and increments `wr_count`, saturating at 64.
  - A repeated address overwrites the earlier value; the last write wins.
  - `done`=1 moves the block to SCAN, or to READY when the macro is absent.
  - If `done` and `IRB_RW`=0 occur on the same edge, the write is committed first and then the transition is taken.
- **SCAN**
  - A 6-bit index runs from 0 to 63, one pixel per cycle.
  - The accumulator adds zero-extended `mem[idx]` each cycle.
  - After idx 63 the result is copied to `checksum` and the state moves to READY.
  - `IRB_RW`=0 during SCAN is ignored.
- **READY**
  - `ready`=1.
  - `rd_en`=1 registers `mem[rd_addr]` into `rd_data` and pulses `rd_valid` on the next cycle.
  - `rd_en` outside READY is dropped: no `rd_valid`, and `rd_data` holds its value.
- **Restart**
  - `IRB_RW`=0 in READY returns the block to CAPTURE on the same edge, and that write is committed.
  - At the restart, `wr_count` becomes 1, and `ready`, `checksum` and the accumulator clear to 0.
  - While in READY, `done` stays high and is ignored. A new seal requires `done` low then high again: the rising edge of `done` is tracked with a registered `done_q`.
- **Arithmetic:** the accumulator is 16 bits and wraps modulo 2^16. The maximum possible sum is 64×255 = 16320, so it does not wrap for 8-bit data.
- The memory is not cleared by reset. Reads of unwritten addresses return X in simulation, and the bench must not depend on them.

## Timing
- **Reset values:**
  - `ready`=0, `rd_valid`=0, `rd_data`=0, `wr_count`=0, `checksum`=0.
  - State = CAPTURE, `done_q`=0.
- Write to memory: 0-cycle decision; the data is readable once READY is reached.
- Seal latency, measured from the edge sampling the `done` rise to `ready`=1:
  - 65 cycles with checksum (1 transition cycle + 64 scan cycles);
  - 1 cycle without checksum.
- Read latency: 1 cycle. Back-to-back `rd_en` gives one `rd_valid` per cycle.
- **`reset_n` asserted mid-SCAN or mid-read:**
  - all outputs go to their reset values immediately;
  - the scan is abandoned and any in-flight `rd_valid` is dropped.

## Configuration
- `IRB_CHECKSUM_EN` defined: the SCAN state, index counter and accumulator are built, and the seal latency is 65 cycles.
- `IRB_CHECKSUM_EN` undefined: SCAN is not built, CAPTURE goes directly to READY, and `checksum` is tied to 0.

## Structure
- Shared package `irb_pkg` holds:
  - the `DEPTH`, `ADDR_W` and `DATA_W` defaults;
  - the state enum `irb_state_t` (CAPTURE, SCAN, READY);
  - the checksum width constant (16).
- One sub-module, `irb_mem`: a 64×8 array with 1 synchronous write port and 1 registered read port.
  - The read port is time-shared between SCAN and host reads; the two never overlap because host reads are READY-only.
- The state machine, counters and accumulator live in `irb_capture`.

## Test plan
- **Ramp write:**
  - Stimulus: write `mem[a]`=a for a=0..63, then raise `done`.
  - Required: `ready` rises 65 cycles later, `checksum`=2016, `wr_count`=64.
  - Required: reading address 37 gives `rd_data`=37 with `rd_valid` one cycle after `rd_en`.
- **Overwrite:**
  - Stimulus: write addr 5 with 0x10 and then 0xFF, fill the rest with 0, raise `done`.
  - Required: `checksum`=255, and a read of addr 5 returns 0xFF.
- **Simultaneous `done` + write:**
  - Stimulus: the final write (addr 63, 0x80) is on the same edge as the `done` rise.
  - Required: the value is stored, and `checksum` includes 0x80.
- **Read outside READY:**
  - Stimulus: `rd_en`=1 during SCAN.
  - Required: no `rd_valid`, and `rd_data` is unchanged.
- **Reset mid-SCAN:**
  - Stimulus: drop `reset_n` at scan idx 20.
  - Required: `ready`=0, `checksum`=0 and `wr_count`=0 immediately; the next capture/seal then completes normally.
- **Restart from READY:**
  - Stimulus: `IRB_RW`=0 while in READY.
  - Required: `ready` drops on that edge and `wr_count`=1.
  - Required: `done` held high does not reseal; a low-then-high pulse on `done` does.

Source files
------------

// File: rtl/irb_pkg.sv
// Shared types and default geometry for the image-result buffer.
package irb_pkg;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CSUM_W = 16;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    SCAN    = 2'd1,
    READY   = 2'd2
  } irb_state_t;

endpackage

// File: rtl/irb_mem.sv
// 64x8 pixel store: one synchronous write port, one registered read port whose
// result lands in either the host or the scan holding register (write-first).
module irb_mem #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] scan_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] host_rdata_d, host_rdata_q;
  logic [DATA_W-1:0] scan_rdata_d, scan_rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A same-edge write to the read address is forwarded so the seal edge sees it.
  always_comb begin
    rd_word      = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    host_rdata_d = host_rdata_q;
    scan_rdata_d = scan_rdata_q;
    if (re) begin
      if (host_sel) begin
        host_rdata_d = rd_word;
      end else begin
        scan_rdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata_q <= '0;
      scan_rdata_q <= '0;
    end else begin
      host_rdata_q <= host_rdata_d;
      scan_rdata_q <= scan_rdata_d;
    end
  end

  assign host_rdata = host_rdata_q;
  assign scan_rdata = scan_rdata_q;

endmodule

// File: rtl/irb_capture.sv
// Captures the 64-pixel IRB write-back, seals on a done rise and serves reads.
// Optional checksum scan is built when IRB_CHECKSUM_EN is defined.
module irb_capture #(
  parameter int unsigned DEPTH  = irb_pkg::DEPTH,
  parameter int unsigned ADDR_W = irb_pkg::ADDR_W,
  parameter int unsigned DATA_W = irb_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       IRB_RW,
  input  logic [ADDR_W-1:0]          IRB_A,
  input  logic [DATA_W-1:0]          IRB_D,
  input  logic                       done,
  input  logic                       rd_en,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       ready,
  output logic [ADDR_W:0]            wr_count,
  output logic [irb_pkg::CSUM_W-1:0] checksum
);
  import irb_pkg::*;

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  irb_state_t        state_q, state_d;
  logic              done_q;
  logic              ready_d, ready_q;
  logic              rd_valid_d, rd_valid_q;
  logic [CNT_W-1:0]  wr_count_d, wr_count_q;
  logic              wr_stb, done_rise;
  logic              mem_we, mem_re, host_sel;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] host_rdata, scan_rdata;

`ifdef IRB_CHECKSUM_EN
  logic [CNT_W-1:0]  scan_idx_d, scan_idx_q;
  logic [CSUM_W-1:0] acc_d, acc_q;
  logic [CSUM_W-1:0] checksum_d, checksum_q;
`else
  logic [DATA_W-1:0] unused_scan;
  assign unused_scan = scan_rdata;
`endif

  assign wr_stb    = ~IRB_RW;
  assign done_rise = done & ~done_q;

  // Read port is shared: host reads in READY, scan fetches otherwise.
  always_comb begin
    mem_we    = wr_stb && (state_q != SCAN);
    host_sel  = (state_q == READY);
    mem_re    = host_sel && rd_en;
    mem_raddr = rd_addr;
`ifdef IRB_CHECKSUM_EN
    if ((state_q == CAPTURE) && done_rise) begin
      mem_re    = 1'b1;
      mem_raddr = '0;
    end else if ((state_q == SCAN) && (scan_idx_q != CNT_FULL)) begin
      mem_re    = 1'b1;
      mem_raddr = scan_idx_q[ADDR_W-1:0];
    end
`endif
  end

  irb_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk        (clk),
    .rst_n      (reset_n),
    .we         (mem_we),
    .waddr      (IRB_A),
    .wdata      (IRB_D),
    .re         (mem_re),
    .host_sel   (host_sel),
    .raddr      (mem_raddr),
    .host_rdata (host_rdata),
    .scan_rdata (scan_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CAPTURE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: begin
        if (done_rise) begin
`ifdef IRB_CHECKSUM_EN
          state_d = SCAN;
`else
          state_d = READY;
`endif
        end
      end
`ifdef IRB_CHECKSUM_EN
      SCAN: begin
        if (scan_idx_q == CNT_FULL) begin
          state_d = READY;
        end
      end
`endif
      READY: begin
        if (wr_stb) begin
          state_d = CAPTURE;
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  // Scan: fetch of pixel 0 is issued on the seal edge, so each SCAN cycle
  // accumulates the previous fetch; the final cycle publishes the sum.
  always_comb begin
    ready_d    = ready_q;
    rd_valid_d = 1'b0;
    wr_count_d = wr_count_q;
`ifdef IRB_CHECKSUM_EN
    scan_idx_d = scan_idx_q;
    acc_d      = acc_q;
    checksum_d = checksum_q;
`endif
    case (state_q)
      CAPTURE: begin
        if (wr_stb && (wr_count_q != CNT_FULL)) begin
          wr_count_d = wr_count_q + CNT_ONE;
        end
        if (done_rise) begin
`ifdef IRB_CHECKSUM_EN
          scan_idx_d = CNT_ONE;
          acc_d      = '0;
`else
          ready_d    = 1'b1;
`endif
        end
      end
`ifdef IRB_CHECKSUM_EN
      SCAN: begin
        acc_d = acc_q + CSUM_W'(scan_rdata);
        if (scan_idx_q == CNT_FULL) begin
          checksum_d = acc_d;
          ready_d    = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q + CNT_ONE;
        end
      end
`endif
      READY: begin
        rd_valid_d = rd_en;
        if (wr_stb) begin
          wr_count_d = CNT_ONE;
          ready_d    = 1'b0;
`ifdef IRB_CHECKSUM_EN
          checksum_d = '0;
          acc_d      = '0;
          scan_idx_d = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_count_q <= '0;
`ifdef IRB_CHECKSUM_EN
      scan_idx_q <= '0;
      acc_q      <= '0;
      checksum_q <= '0;
`endif
    end else begin
      done_q     <= done;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      wr_count_q <= wr_count_d;
`ifdef IRB_CHECKSUM_EN
      scan_idx_q <= scan_idx_d;
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
`endif
    end
  end

  assign rd_data  = host_rdata;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_q;
  assign wr_count = wr_count_q;
`ifdef IRB_CHECKSUM_EN
  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_irb_capture.sv
// Directed/randomized bench for irb_capture against an array-based image model.
module tb_irb_capture;

`ifdef IRB_CHECKSUM_EN
  localparam bit CK       = 1'b1;
  localparam int SEAL_LAT = 65;
`else
  localparam bit CK       = 1'b0;
  localparam int SEAL_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        IRB_RW = 1'b1;
  logic [5:0]  IRB_A = '0;
  logic [7:0]  IRB_D = '0;
  logic        done = 1'b0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        ready;
  logic [6:0]  wr_count;
  logic [15:0] checksum;

  irb_capture dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .IRB_RW   (IRB_RW),
    .IRB_A    (IRB_A),
    .IRB_D    (IRB_D),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .ready    (ready),
    .wr_count (wr_count),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int mem_m [64];
  int wr_m = 0;
  int rd_m = 0;
  bit sealed = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_csum();
    int s = 0;
    for (int i = 0; i < 64; i++) s += mem_m[i];
    return CK ? (s % 65536) : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of one accepted write: a write while sealed restarts the count.
  task automatic model_write(input int a, input int d);
    mem_m[a] = d;
    if (sealed) begin
      wr_m   = 1;
      sealed = 1'b0;
    end else begin
      wr_m = (wr_m < 64) ? wr_m + 1 : 64;
    end
  endtask

  task automatic wr(input int a, input int d);
    IRB_RW = 1'b0;
    IRB_A  = 6'(a);
    IRB_D  = 8'(d);
    step();
    IRB_RW = 1'b1;
    model_write(a, d);
  endtask

  task automatic seal(input string tag, input bit with_wr, input int a, input int d, input bit probe);
    int lat;
    done = 1'b1;
    if (with_wr) begin
      IRB_RW = 1'b0;
      IRB_A  = 6'(a);
      IRB_D  = 8'(d);
      model_write(a, d);
    end
    step();
    IRB_RW = 1'b1;
    lat = 1;
    while (ready !== 1'b1 && lat < 200) begin
      if (probe) begin
        rd_en   = 1'b1;
        rd_addr = 6'($urandom);
      end
      step();
      if (probe) begin
        check({tag, "_busy_rdvalid"}, 32'(rd_valid), 0);
        check({tag, "_busy_rddata"}, 32'(rd_data), rd_m);
      end
      lat++;
    end
    rd_en = 1'b0;
    check({tag, "_seal_latency"}, lat, SEAL_LAT);
    check({tag, "_ready"}, 32'(ready), 1);
    check({tag, "_checksum"}, 32'(checksum), exp_csum());
    check({tag, "_wr_count"}, 32'(wr_count), wr_m);
    sealed = 1'b1;
  endtask

  task automatic rd_one(input string tag, input int a);
    rd_en   = 1'b1;
    rd_addr = 6'(a);
    step();
    rd_en = 1'b0;
    check({tag, "_rdvalid"}, 32'(rd_valid), 1);
    check({tag, "_rddata"}, 32'(rd_data), mem_m[a]);
    rd_m = mem_m[a];
    step();
    check({tag, "_rdvalid_pulse"}, 32'(rd_valid), 0);
  endtask

  task automatic rd_burst(input string tag, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a       = int'($urandom_range(63));
      rd_en   = 1'b1;
      rd_addr = 6'(a);
      step();
      check({tag, "_burst_rdvalid"}, 32'(rd_valid), 1);
      check({tag, "_burst_rddata"}, 32'(rd_data), mem_m[a]);
      rd_m = mem_m[a];
    end
    rd_en = 1'b0;
    step();
    check({tag, "_burst_end_rdvalid"}, 32'(rd_valid), 0);
    check({tag, "_burst_hold"}, 32'(rd_data), rd_m);
  endtask

  task automatic fill_random(input int first);
    for (int a = first; a < 64; a++) wr(a, int'($urandom_range(255)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check("rst_ready", 32'(ready), 0);
    check("rst_rdvalid", 32'(rd_valid), 0);
    check("rst_rddata", 32'(rd_data), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_checksum", 32'(checksum), 0);
    reset_n = 1'b1;
    step();

    // Ramp image
    for (int a = 0; a < 64; a++) wr(a, a);
    check("ramp_wr_count", 32'(wr_count), 64);
    seal("ramp", 1'b0, 0, 0, 1'b0);
    check("ramp_checksum_const", 32'(checksum), CK ? 2016 : 0);
    rd_one("ramp37", 37);
    rd_burst("ramp", 8);

    // Restart from READY with done still high, then overwrite image
    wr(5, 'h10);
    check("restart_ready", 32'(ready), 0);
    check("restart_wr_count", 32'(wr_count), 1);
    check("restart_checksum", 32'(checksum), 0);
    wr(5, 'hFF);
    for (int a = 0; a < 64; a++) if (a != 5) wr(a, 0);
    check("ovr_wr_count_sat", 32'(wr_count), 64);
    rd_en   = 1'b1;
    rd_addr = 6'd5;
    repeat (2) begin
      step();
      check("capture_rd_rdvalid", 32'(rd_valid), 0);
      check("capture_rd_hold", 32'(rd_data), rd_m);
    end
    rd_en = 1'b0;
    repeat (5) step();
    check("held_done_no_reseal", 32'(ready), 0);
    done = 1'b0;
    step();
    seal("ovr", 1'b0, 0, 0, 1'b0);
    check("ovr_checksum_const", 32'(checksum), CK ? 255 : 0);
    rd_one("ovr5", 5);

    // Final write on the same edge as the done rise, reads probed while busy
    wr(0, int'($urandom_range(255)));
    done = 1'b0;
    for (int a = 1; a < 63; a++) wr(a, int'($urandom_range(255)));
    for (int i = 0; i < 10; i++) wr(int'($urandom_range(62)), int'($urandom_range(255)));
    seal("simul", 1'b1, 63, 'h80, 1'b1);
    rd_one("simul63", 63);
    rd_burst("simul", 6);

    // Reset in the middle of the scan
    wr(0, int'($urandom_range(255)));
    done = 1'b0;
    fill_random(1);
    done = 1'b1;
    step();
    repeat (20) step();
    reset_n = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 0);
    check("midrst_checksum", 32'(checksum), 0);
    check("midrst_wr_count", 32'(wr_count), 0);
    check("midrst_rdvalid", 32'(rd_valid), 0);
    check("midrst_rddata", 32'(rd_data), 0);
    rd_m   = 0;
    wr_m   = 0;
    sealed = 1'b0;
    done   = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    fill_random(0);
    for (int i = 0; i < 5; i++) wr(int'($urandom_range(63)), int'($urandom_range(255)));
    seal("post_rst", 1'b0, 0, 0, 1'b1);
    rd_burst("post_rst", 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
